// File: rtl/pc_sequencer.sv
// Control sequencer for the Beta PC unit: boot, trap/interrupt arbitration, stall and flush.
// Outputs are combinational from the current state and the live inputs.
module pc_sequencer #(
   parameter int unsigned NUM_IRQ      = 4,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ill_op,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               in_kernel,
   input  logic               mem_busy,
   input  logic               ld_hazard,
   input  logic [31:0]        exc_pc,
   output logic               stall,
   output logic [1:0]         pc_ctrl,
   output logic               flush,
   output logic               xp_we,
   output logic [31:0]        xp_data,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [1:0]         seq_state
);

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } state_e;

   localparam int unsigned CntW = 3;
   // Counter holds the number of flush cycles still to go after the current one.
   localparam logic [CntW-1:0] CntLoad = CntW'(FLUSH_CYCLES - 1);

   state_e              state_q, state_d;
   logic   [CntW-1:0]   cnt_q, cnt_d;
   logic   [NUM_IRQ-1:0] pend;
   logic   [NUM_IRQ-1:0] pend_low;

   assign pend      = irq_req & irq_mask;
   // Two's-complement trick isolates the lowest set bit.
   assign pend_low  = pend & (~pend + NUM_IRQ'(1));
   assign seq_state = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StBoot;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      pc_ctrl = 2'd0;
      flush   = 1'b0;
      xp_we   = 1'b0;
      xp_data = '0;
      irq_ack = '0;
      unique case (state_q)
         StBoot: begin
            pc_ctrl = 2'd1;
            flush   = 1'b1;
            state_d = StRun;
         end
         StRun: begin
            if (mem_busy) begin
               stall = 1'b1;
            end else if (ill_op) begin
               pc_ctrl = 2'd2;
               xp_we   = 1'b1;
               xp_data = exc_pc;
               state_d = StFlush;
               cnt_d   = CntLoad;
            end else if (!in_kernel && (pend != '0)) begin
               pc_ctrl = 2'd3;
               xp_we   = 1'b1;
               xp_data = exc_pc;
               irq_ack = pend_low;
               state_d = StFlush;
               cnt_d   = CntLoad;
            end else if (ld_hazard) begin
               stall = 1'b1;
            end
         end
         StFlush: begin
            flush = 1'b1;
            if (mem_busy) begin
               stall = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StBoot;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver pushes model predictions per cycle,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_pc_sequencer;

   localparam int unsigned NI = 4;
   localparam int unsigned FC = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ill_op = 1'b0;
   logic [NI-1:0] irq_req = '0;
   logic [NI-1:0] irq_mask = '0;
   logic          in_kernel = 1'b0;
   logic          mem_busy = 1'b0;
   logic          ld_hazard = 1'b0;
   logic [31:0]   exc_pc = '0;
   logic          stall;
   logic [1:0]    pc_ctrl;
   logic          flush;
   logic          xp_we;
   logic [31:0]   xp_data;
   logic [NI-1:0] irq_ack;
   logic [1:0]    seq_state;

   pc_sequencer #(.NUM_IRQ(NI), .FLUSH_CYCLES(FC)) dut (
      .clk       (clk),
      .reset     (reset),
      .ill_op    (ill_op),
      .irq_req   (irq_req),
      .irq_mask  (irq_mask),
      .in_kernel (in_kernel),
      .mem_busy  (mem_busy),
      .ld_hazard (ld_hazard),
      .exc_pc    (exc_pc),
      .stall     (stall),
      .pc_ctrl   (pc_ctrl),
      .flush     (flush),
      .xp_we     (xp_we),
      .xp_data   (xp_data),
      .irq_ack   (irq_ack),
      .seq_state (seq_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          stall;
      logic [1:0]    pc_ctrl;
      logic          flush;
      logic          xp_we;
      logic [31:0]   xp_data;
      logic [NI-1:0] irq_ack;
      logic [1:0]    st;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: "booting" flag plus number of flush cycles left (0 = running).
   bit   booting    = 1'b1;
   int   flush_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("seq_state", 32'(seq_state), 32'(e.st));
            chk("stall",     32'(stall),     32'(e.stall));
            chk("pc_ctrl",   32'(pc_ctrl),   32'(e.pc_ctrl));
            chk("flush",     32'(flush),     32'(e.flush));
            chk("xp_we",     32'(xp_we),     32'(e.xp_we));
            chk("xp_data",   xp_data,        e.xp_data);
            chk("irq_ack",   32'(irq_ack),   32'(e.irq_ack));
         end
      end
   end

   task automatic step(input logic r, input logic io, input logic [NI-1:0] rq,
                       input logic [NI-1:0] mk, input logic k, input logic mb,
                       input logic lh, input logic [31:0] pc);
      exp_t          e;
      logic [NI-1:0] pend;
      @(posedge clk);
      #1;
      reset = r; ill_op = io; irq_req = rq; irq_mask = mk;
      in_kernel = k; mem_busy = mb; ld_hazard = lh; exc_pc = pc;
      e = '0;
      pend = rq & mk;
      if (r || booting) begin
         e.st = 2'd0; e.pc_ctrl = 2'd1; e.flush = 1'b1;
         booting = r;
         flush_left = 0;
      end else if (flush_left > 0) begin
         e.st = 2'd2; e.flush = 1'b1; e.stall = mb;
         if (!mb) flush_left = flush_left - 1;
      end else begin
         e.st = 2'd1;
         if (mb) begin
            e.stall = 1'b1;
         end else if (io) begin
            e.pc_ctrl = 2'd2; e.xp_we = 1'b1; e.xp_data = pc;
            flush_left = FC;
         end else if (!k && pend != 0) begin
            e.pc_ctrl = 2'd3; e.xp_we = 1'b1; e.xp_data = pc;
            for (int i = 0; i < NI; i++) begin
               if (pend[i] && e.irq_ack == 0) e.irq_ack[i] = 1'b1;
            end
            flush_left = FC;
         end else if (lh) begin
            e.stall = 1'b1;
         end
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      // Reset, boot, run.
      for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, 0, 0, 32'h0);
      idle(3);
      // Illegal opcode held through the flush.
      step(0, 1, '0, '0, 0, 0, 0, 32'h0000_0104);
      for (int i = 0; i < 2; i++) step(0, 1, '0, '0, 0, 0, 0, 32'h0000_0108);
      idle(1);
      // Two pending interrupts: lowest first, the other after the flush.
      step(0, 0, 4'b0110, 4'b1111, 0, 0, 0, 32'h0000_0200);
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0100, 4'b1111, 0, 0, 0, 32'h0000_0204);
      step(0, 0, 4'b0000, 4'b1111, 0, 0, 0, 32'h0);
      idle(2);
      // Kernel mode blocks interrupts until dropped.
      for (int i = 0; i < 5; i++) step(0, 0, 4'b0001, 4'b1111, 1, 0, 0, 32'h8000_0010);
      step(0, 0, 4'b0001, 4'b1111, 0, 0, 0, 32'h0000_0300);
      idle(3);
      // Memory wait freezes everything, then the trap is taken.
      for (int i = 0; i < 4; i++) step(0, 1, '0, '0, 0, 1, 1, 32'h0000_0400);
      step(0, 1, '0, '0, 0, 0, 1, 32'h0000_0404);
      step(0, 0, '0, '0, 0, 1, 0, 32'h0);
      idle(3);
      // Reset during the second flush cycle.
      step(0, 1, '0, '0, 0, 0, 0, 32'h0000_0500);
      idle(1);
      step(1, 0, '0, '0, 0, 0, 0, 32'h0);
      step(1, 0, '0, '0, 0, 0, 0, 32'h0);
      idle(1);
      step(0, 0, '0, '0, 0, 0, 1, 32'h0);
      idle(2);
      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         step(($urandom_range(199) == 0), ($urandom_range(9) == 0),
              NI'($urandom), NI'($urandom), ($urandom_range(2) == 0),
              ($urandom_range(5) == 0), ($urandom_range(3) == 0), $urandom);
      end
      idle(2);
      for (int i = 0; i < 5 && q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
